// File: rtl/verlet_frame_sequencer_pkg.sv
// Shared definitions for the Verlet frame sequencer.
//   - FSM state encodings (3-bit constants)
//   - Q20.12 position word format constants
//   - pair_t: the four operand/result words of one constraint pair
//   - word_lsb(): bit offset of node k inside a packed position vector
//   - cnt_width(): counter width that never collapses to zero bits
package verlet_frame_sequencer_pkg;

    localparam int WORD      = 32;
    localparam int FRAC_BITS = 12;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VERLET  = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_LOAD    = 3'd3;
    localparam logic [2:0] ST_REQ     = 3'd4;
    localparam logic [2:0] ST_WRITE_A = 3'd5;
    localparam logic [2:0] ST_WRITE_B = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    typedef struct packed {
        logic [WORD-1:0] ax;
        logic [WORD-1:0] ay;
        logic [WORD-1:0] bx;
        logic [WORD-1:0] by;
    } pair_t;

    function automatic int word_lsb(input int k);
        return k * WORD;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/verlet_frame_sequencer_if.sv
// Node-array and constraint-unit bus for the Verlet frame sequencer.
//   master : sequencer side (drives strobes, write-back bus, c_req/operands)
//   slave  : node array + constraint unit side
// Signals:
//   x_pos_all/y_pos_all   packed node positions, node k at [32k+31:32k]
//   verlet_state          one-cycle integration strobe to all nodes
//   fix_constraint_state  one-hot write enable, bit k writes node k
//   x/y_fix_constraint    shared corrected-position bus
//   c_req/c_ack           constraint request / result-valid handshake
//   c_ax..c_by, c_pin_a   pair operands and anchor flag
//   c_ax_out..c_by_out    corrected pair, valid with c_ack
interface verlet_frame_sequencer_if
    import verlet_frame_sequencer_pkg::*;
#(
    parameter int NUM_NODES = 8
);
    logic [WORD*NUM_NODES-1:0] x_pos_all;
    logic [WORD*NUM_NODES-1:0] y_pos_all;
    logic                      verlet_state;
    logic [NUM_NODES-1:0]      fix_constraint_state;
    logic [WORD-1:0]           x_fix_constraint;
    logic [WORD-1:0]           y_fix_constraint;

    logic                      c_req;
    logic                      c_ack;
    logic                      c_pin_a;
    logic [WORD-1:0]           c_ax;
    logic [WORD-1:0]           c_ay;
    logic [WORD-1:0]           c_bx;
    logic [WORD-1:0]           c_by;
    logic [WORD-1:0]           c_ax_out;
    logic [WORD-1:0]           c_ay_out;
    logic [WORD-1:0]           c_bx_out;
    logic [WORD-1:0]           c_by_out;

    modport master (
        input  x_pos_all, y_pos_all, c_ack,
               c_ax_out, c_ay_out, c_bx_out, c_by_out,
        output verlet_state, fix_constraint_state,
               x_fix_constraint, y_fix_constraint,
               c_req, c_pin_a, c_ax, c_ay, c_bx, c_by
    );

    modport slave (
        output x_pos_all, y_pos_all, c_ack,
               c_ax_out, c_ay_out, c_bx_out, c_by_out,
        input  verlet_state, fix_constraint_state,
               x_fix_constraint, y_fix_constraint,
               c_req, c_pin_a, c_ax, c_ay, c_bx, c_by
    );

endinterface

// File: rtl/verlet_frame_sequencer.sv
// Verlet frame sequencer: per frame, one integration strobe to every node,
// then CONSTRAINT_ITERS relaxation passes over pairs (i, i+1). Each pair is
// loaded, sent to the external constraint unit, and the two results are
// written back one node per cycle on the shared fix bus.
// Ports:
//   clk, reset (synchronous, active-low)
//   start       frame request, only honoured in IDLE
//   nb          node/constraint bus (master modport)
//   busy        high in every state but IDLE
//   frame_done  one-cycle pulse in the DONE state
//   overrun     start seen while busy (combinational, same cycle)
module verlet_frame_sequencer
    import verlet_frame_sequencer_pkg::*;
#(
    parameter int NUM_NODES        = 8,
    parameter int CONSTRAINT_ITERS = 4,
    parameter int PIN_FIRST        = 1
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    verlet_frame_sequencer_if.master nb,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);

    localparam int I_W   = cnt_width(NUM_NODES);
    localparam int IT_W  = cnt_width(CONSTRAINT_ITERS);
    localparam int SEL_W = $clog2(WORD * NUM_NODES);
    localparam logic [I_W-1:0]  I_LAST  = I_W'(NUM_NODES - 2);
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(CONSTRAINT_ITERS - 1);
    localparam logic            PIN     = (PIN_FIRST != 0);

    logic [2:0]      state_reg, state_next;
    logic [I_W-1:0]  i_reg, i_next;
    logic [IT_W-1:0] it_reg, it_next;
    pair_t           opnd_reg;
    pair_t           res_reg;
    logic            pin_reg;

    // Pair-select mux: A = node i, B = node i+1.
    logic [SEL_W-1:0] a_lsb, b_lsb;
    assign a_lsb = SEL_W'(word_lsb(int'(i_reg)));
    assign b_lsb = SEL_W'(word_lsb(int'(i_reg) + 1));

    // Anchored node 0 keeps its write slot but never gets a strobe.
    logic pinned_pair;
    assign pinned_pair = PIN && (i_reg == '0);

    always_comb begin
        state_next = state_reg;
        i_next     = i_reg;
        it_next    = it_reg;
        case (state_reg)
            ST_IDLE:    if (start) state_next = ST_VERLET;
            ST_VERLET:  state_next = ST_SETTLE;
            ST_SETTLE:  state_next = ST_LOAD;
            ST_LOAD:    state_next = ST_REQ;
            ST_REQ:     if (nb.c_ack) state_next = ST_WRITE_A;
            ST_WRITE_A: state_next = ST_WRITE_B;
            ST_WRITE_B: begin
                if (i_reg < I_LAST) begin
                    i_next     = i_reg + 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    i_next = '0;
                    if (it_reg < IT_LAST) begin
                        it_next    = it_reg + 1'b1;
                        state_next = ST_LOAD;
                    end else begin
                        it_next    = '0;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            i_reg     <= '0;
            it_reg    <= '0;
            opnd_reg  <= '0;
            res_reg   <= '0;
            pin_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            it_reg    <= it_next;
            if (state_reg == ST_LOAD) begin
                opnd_reg.ax <= nb.x_pos_all[a_lsb +: WORD];
                opnd_reg.ay <= nb.y_pos_all[a_lsb +: WORD];
                opnd_reg.bx <= nb.x_pos_all[b_lsb +: WORD];
                opnd_reg.by <= nb.y_pos_all[b_lsb +: WORD];
                pin_reg     <= pinned_pair;
            end
            if (state_reg == ST_REQ && nb.c_ack) begin
                res_reg.ax <= nb.c_ax_out;
                res_reg.ay <= nb.c_ay_out;
                res_reg.bx <= nb.c_bx_out;
                res_reg.by <= nb.c_by_out;
            end
        end
    end

    logic [NUM_NODES-1:0] fix_vec;
    logic [WORD-1:0]      x_fix, y_fix;

    always_comb begin
        fix_vec = '0;
        x_fix   = '0;
        y_fix   = '0;
        case (state_reg)
            ST_WRITE_A: begin
                x_fix = res_reg.ax;
                y_fix = res_reg.ay;
                if (!pinned_pair) fix_vec = NUM_NODES'(1) << i_reg;
            end
            ST_WRITE_B: begin
                x_fix   = res_reg.bx;
                y_fix   = res_reg.by;
                fix_vec = NUM_NODES'(1) << (i_reg + 1'b1);
            end
            default: ;
        endcase
    end

    assign nb.fix_constraint_state = fix_vec;
    assign nb.x_fix_constraint     = x_fix;
    assign nb.y_fix_constraint     = y_fix;
    assign nb.verlet_state         = (state_reg == ST_VERLET);
    assign nb.c_req                = (state_reg == ST_REQ);
    assign nb.c_ax                 = opnd_reg.ax;
    assign nb.c_ay                 = opnd_reg.ay;
    assign nb.c_bx                 = opnd_reg.bx;
    assign nb.c_by                 = opnd_reg.by;
    assign nb.c_pin_a              = pin_reg;

    assign busy       = (state_reg != ST_IDLE);
    assign frame_done = (state_reg == ST_DONE);
    assign overrun    = start && busy;

endmodule

// File: tb/tb_verlet_frame_sequencer.sv
// Bench for verlet_frame_sequencer: three instances (defaults; 3 nodes/1 pass
// pinned; 3 nodes/1 pass unpinned), each with a node-array model and a
// constraint-unit model adding 1.0 (Q20.12) to every operand.
module tb_verlet_frame_sequencer;
    import verlet_frame_sequencer_pkg::*;

    localparam logic [31:0] STEP = 32'(1) << FRAC_BITS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] start_v;
    logic [2:0] busy_v, done_v, ovr_v;
    int         ack_delay;
    logic       ack_force;
    int         wait_cnt = 0;

    verlet_frame_sequencer_if #(.NUM_NODES(8)) if_a ();
    verlet_frame_sequencer_if #(.NUM_NODES(3)) if_b ();
    verlet_frame_sequencer_if #(.NUM_NODES(3)) if_c ();

    verlet_frame_sequencer #(.NUM_NODES(8), .CONSTRAINT_ITERS(4), .PIN_FIRST(1)) u_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .nb(if_a),
        .busy(busy_v[0]), .frame_done(done_v[0]), .overrun(ovr_v[0]));
    verlet_frame_sequencer #(.NUM_NODES(3), .CONSTRAINT_ITERS(1), .PIN_FIRST(1)) u_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .nb(if_b),
        .busy(busy_v[1]), .frame_done(done_v[1]), .overrun(ovr_v[1]));
    verlet_frame_sequencer #(.NUM_NODES(3), .CONSTRAINT_ITERS(1), .PIN_FIRST(0)) u_c (
        .clk(clk), .reset(reset), .start(start_v[2]), .nb(if_c),
        .busy(busy_v[2]), .frame_done(done_v[2]), .overrun(ovr_v[2]));

    // Constraint-unit models.
    always @(posedge clk) wait_cnt <= if_a.c_req ? wait_cnt + 1 : 0;
    assign if_a.c_ack = (if_a.c_req && (wait_cnt >= ack_delay)) || ack_force;
    assign if_b.c_ack = if_b.c_req;
    assign if_c.c_ack = if_c.c_req;
    assign if_a.c_ax_out = if_a.c_ax + STEP;  assign if_a.c_ay_out = if_a.c_ay + STEP;
    assign if_a.c_bx_out = if_a.c_bx + STEP;  assign if_a.c_by_out = if_a.c_by + STEP;
    assign if_b.c_ax_out = if_b.c_ax + STEP;  assign if_b.c_ay_out = if_b.c_ay + STEP;
    assign if_b.c_bx_out = if_b.c_bx + STEP;  assign if_b.c_by_out = if_b.c_by + STEP;
    assign if_c.c_ax_out = if_c.c_ax + STEP;  assign if_c.c_ay_out = if_c.c_ay + STEP;
    assign if_c.c_bx_out = if_c.c_bx + STEP;  assign if_c.c_by_out = if_c.c_by + STEP;

    function automatic logic [31:0] init_x(input int k);
        return 32'h000C_8000 + 32'(k) * 0;
    endfunction
    function automatic logic [31:0] init_y(input int k);
        return 32'h0000_A000 * 32'(k + 1);
    endfunction

    // Node-array models: reload initial positions on reset, take fix writes.
    logic [31:0] nx_a [8], ny_a [8], nx_b [3], ny_b [3], nx_c [3], ny_c [3];
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (!reset) begin
                nx_a[k] <= init_x(k); ny_a[k] <= init_y(k);
            end else if (if_a.fix_constraint_state[k]) begin
                nx_a[k] <= if_a.x_fix_constraint; ny_a[k] <= if_a.y_fix_constraint;
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                nx_b[k] <= init_x(k); ny_b[k] <= init_y(k);
                nx_c[k] <= init_x(k); ny_c[k] <= init_y(k);
            end else begin
                if (if_b.fix_constraint_state[k]) begin
                    nx_b[k] <= if_b.x_fix_constraint; ny_b[k] <= if_b.y_fix_constraint;
                end
                if (if_c.fix_constraint_state[k]) begin
                    nx_c[k] <= if_c.x_fix_constraint; ny_c[k] <= if_c.y_fix_constraint;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pack_a
            assign if_a.x_pos_all[32*gi +: 32] = nx_a[gi];
            assign if_a.y_pos_all[32*gi +: 32] = ny_a[gi];
        end
        for (gi = 0; gi < 3; gi++) begin : g_pack_bc
            assign if_b.x_pos_all[32*gi +: 32] = nx_b[gi];
            assign if_b.y_pos_all[32*gi +: 32] = ny_b[gi];
            assign if_c.x_pos_all[32*gi +: 32] = nx_c[gi];
            assign if_c.y_pos_all[32*gi +: 32] = ny_c[gi];
        end
    endgenerate

    // Uniform views of the three instances for the monitor and tasks.
    logic [2:0]  req_v, ack_v, pin_v, verl_v;
    logic [31:0] ax_v [3], ay_v [3], bx_v [3], by_v [3], fx_v [3], fy_v [3];
    logic [7:0]  fix_v [3];
    assign req_v  = {if_c.c_req, if_b.c_req, if_a.c_req};
    assign ack_v  = {if_c.c_ack, if_b.c_ack, if_a.c_ack};
    assign pin_v  = {if_c.c_pin_a, if_b.c_pin_a, if_a.c_pin_a};
    assign verl_v = {if_c.verlet_state, if_b.verlet_state, if_a.verlet_state};
    assign ax_v[0] = if_a.c_ax; assign ay_v[0] = if_a.c_ay; assign bx_v[0] = if_a.c_bx; assign by_v[0] = if_a.c_by;
    assign ax_v[1] = if_b.c_ax; assign ay_v[1] = if_b.c_ay; assign bx_v[1] = if_b.c_bx; assign by_v[1] = if_b.c_by;
    assign ax_v[2] = if_c.c_ax; assign ay_v[2] = if_c.c_ay; assign bx_v[2] = if_c.c_bx; assign by_v[2] = if_c.c_by;
    assign fx_v[0] = if_a.x_fix_constraint; assign fy_v[0] = if_a.y_fix_constraint;
    assign fx_v[1] = if_b.x_fix_constraint; assign fy_v[1] = if_b.y_fix_constraint;
    assign fx_v[2] = if_c.x_fix_constraint; assign fy_v[2] = if_c.y_fix_constraint;
    assign fix_v[0] = if_a.fix_constraint_state;
    assign fix_v[1] = {5'b0, if_b.fix_constraint_state};
    assign fix_v[2] = {5'b0, if_c.fix_constraint_state};

    typedef struct { int d; logic [31:0] ax, ay, bx, by; logic pin; } req_t;
    typedef struct { int d; int idx; logic [31:0] x, y; } wr_t;
    req_t req_q [$];
    wr_t  wr_q  [$];

    int         errors = 0;
    int         checks = 0;
    int         strobes [3];
    logic [2:0] pin_seen;
    bit         mon_en = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected requests and write-backs of one frame, from the bench's own
    // copy of the initial node positions.
    task automatic gen_frame(input int d, input int n, input int iters, input bit pin);
        logic [31:0] x [8], y [8];
        logic [31:0] ax, ay, bx, by;
        for (int k = 0; k < n; k++) begin x[k] = init_x(k); y[k] = init_y(k); end
        for (int it = 0; it < iters; it++) begin
            for (int i = 0; i < n - 1; i++) begin
                req_q.push_back('{d, x[i], y[i], x[i+1], y[i+1], pin && (i == 0)});
                ax = x[i] + STEP; ay = y[i] + STEP; bx = x[i+1] + STEP; by = y[i+1] + STEP;
                if (!(pin && i == 0)) begin
                    wr_q.push_back('{d, i, ax, ay});
                    x[i] = ax; y[i] = ay;
                end
                wr_q.push_back('{d, i + 1, bx, by});
                x[i+1] = bx; y[i+1] = by;
            end
        end
    endtask

    // Scoreboard monitor: operands while c_req is up, data on every strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (pin_v[d]) pin_seen[d] = 1'b1;
                if (fix_v[d] != 8'd0) begin
                    strobes[d]++;
                    chk("fix_onehot", 64'($onehot(fix_v[d])), 64'd1);
                    chk("verlet_with_fix", 64'(verl_v[d]), 64'd0);
                    if (wr_q.size() == 0) chk("wr_unexpected", 64'(fix_v[d]), 64'd0);
                    else begin
                        wr_t w;
                        w = wr_q.pop_front();
                        chk("wr_dut", 64'(d), 64'(w.d));
                        chk("wr_idx", 64'(fix_v[d]), 64'(8'd1 << w.idx));
                        chk("wr_x", 64'(fx_v[d]), 64'(w.x));
                        chk("wr_y", 64'(fy_v[d]), 64'(w.y));
                    end
                end
                if (req_v[d]) begin
                    if (req_q.size() == 0) chk("req_unexpected", 64'(req_v[d]), 64'd0);
                    else begin
                        req_t r;
                        r = req_q[0];
                        chk("req_dut", 64'(d), 64'(r.d));
                        chk("req_a", {ax_v[d], ay_v[d]}, {r.ax, r.ay});
                        chk("req_b", {bx_v[d], by_v[d]}, {r.bx, r.by});
                        chk("req_pin", 64'(pin_v[d]), 64'(r.pin));
                        if (ack_v[d]) void'(req_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic chk_idle(input int d);
        chk("idle_busy", 64'(busy_v[d]), 64'd0);
        chk("idle_done", 64'(done_v[d]), 64'd0);
        chk("idle_verlet", 64'(verl_v[d]), 64'd0);
        chk("idle_fix", 64'(fix_v[d]), 64'd0);
        chk("idle_req", 64'(req_v[d]), 64'd0);
        chk("idle_pin", 64'(pin_v[d]), 64'd0);
        chk("idle_opa", {ax_v[d], ay_v[d]}, 64'd0);
        chk("idle_opb", {bx_v[d], by_v[d]}, 64'd0);
        chk("idle_bus", {fx_v[d], fy_v[d]}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        req_q.delete();
        wr_q.delete();
        for (int d = 0; d < 3; d++) strobes[d] = 0;
        pin_seen = 3'b000;
    endtask

    // Start a frame; k counts cycles after the accepting edge (verlet at k=1).
    task automatic run_frame(input int d, input int budget, input int ovr_k, input bit ovr_done,
                             output int done_k, output int vcount, output int vfirst,
                             output logic [7:0] fix5, output logic [7:0] fix6);
        done_k = -1; vcount = 0; vfirst = -1; fix5 = 8'hFF; fix6 = 8'hFF;
        @(posedge clk); #1 start_v[d] = 1'b1;
        @(posedge clk); #1 start_v[d] = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            if (verl_v[d]) begin vcount++; if (vfirst < 0) vfirst = k; end
            if (k == 5) fix5 = fix_v[d];
            if (k == 6) fix6 = fix_v[d];
            if (k == ovr_k) begin
                start_v[d] = 1'b1;
                #1 chk("overrun_mid", 64'(ovr_v[d]), 64'd1);
            end
            if (done_v[d]) begin
                done_k = k;
                if (ovr_done) begin
                    start_v[d] = 1'b1;
                    #1 chk("overrun_done", 64'(ovr_v[d]), 64'd1);
                    @(negedge clk) start_v[d] = 1'b0;
                end
                break;
            end
        end
        $display("frame dut=%0d done_k=%0d verlet_pulses=%0d first_verlet=%0d", d, done_k, vcount, vfirst);
    endtask

    int         dk, vc, vf;
    logic [7:0] f5, f6;

    initial begin
        reset = 1'b0; start_v = 3'b000; ack_delay = 0; ack_force = 1'b0; pin_seen = 3'b000;
        for (int d = 0; d < 3; d++) strobes[d] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) chk_idle(d);
        reset = 1'b1;
        mon_en = 1;

        // 3 nodes, 1 pass, node 0 pinned.
        gen_frame(1, 3, 1, 1'b1);
        run_frame(1, 40, -1, 1'b0, dk, vc, vf, f5, f6);
        chk("b_done_k", 64'(dk), 64'd11);
        chk("b_verlet_count", 64'(vc), 64'd1);
        chk("b_verlet_k", 64'(vf), 64'd1);
        chk("b_pinned_write_a", 64'(f5), 64'd0);
        chk("b_write_b", 64'(f6), 64'b010);
        chk("b_node1_x", 64'(nx_b[1]), 64'h0CA000);
        chk("b_pin_seen", 64'(pin_seen[1]), 64'd1);
        chk("b_queues_empty", 64'(req_q.size() + wr_q.size()), 64'd0);

        // Same, unpinned.
        gen_frame(2, 3, 1, 1'b0);
        run_frame(2, 40, -1, 1'b0, dk, vc, vf, f5, f6);
        chk("c_done_k", 64'(dk), 64'd11);
        chk("c_write_a_bit0", 64'(f5), 64'b001);
        chk("c_pin_never", 64'(pin_seen[2]), 64'd0);
        chk("c_queues_empty", 64'(req_q.size() + wr_q.size()), 64'd0);

        // Defaults, zero-wait ack.
        do_reset();
        gen_frame(0, 8, 4, 1'b1);
        run_frame(0, 200, -1, 1'b0, dk, vc, vf, f5, f6);
        chk("a_done_k", 64'(dk), 64'd115);
        chk("a_verlet_count", 64'(vc), 64'd1);
        chk("a_verlet_k", 64'(vf), 64'd1);
        chk("a_strobes", 64'(strobes[0]), 64'd52);
        chk("a_queues_empty", 64'(req_q.size() + wr_q.size()), 64'd0);

        // Ack delayed 3 cycles on every request.
        do_reset();
        ack_delay = 3;
        gen_frame(0, 8, 4, 1'b1);
        run_frame(0, 300, -1, 1'b0, dk, vc, vf, f5, f6);
        chk("a_slow_done_k", 64'(dk), 64'd199);
        chk("a_slow_strobes", 64'(strobes[0]), 64'd52);
        chk("a_slow_queues_empty", 64'(req_q.size() + wr_q.size()), 64'd0);

        // Overrun mid-frame and in the DONE cycle; nothing restarts.
        do_reset();
        ack_delay = 0;
        gen_frame(0, 8, 4, 1'b1);
        run_frame(0, 200, 10, 1'b1, dk, vc, vf, f5, f6);
        chk("ovr_done_k", 64'(dk), 64'd115);
        chk("ovr_verlet_count", 64'(vc), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ovr_no_restart", 64'(busy_v[0]), 64'd0);
        end
        do_reset();
        gen_frame(0, 8, 4, 1'b1);
        run_frame(0, 200, -1, 1'b0, dk, vc, vf, f5, f6);
        chk("after_ovr_done_k", 64'(dk), 64'd115);

        // Reset while c_req is held.
        do_reset();
        ack_delay = 20;
        gen_frame(0, 8, 4, 1'b1);
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_v[0]) break;
        end
        chk("rst_req_reached", 64'(req_v[0]), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk_idle(0);
        reset = 1'b1;
        req_q.delete();
        wr_q.delete();
        ack_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ack_ignored_busy", 64'(busy_v[0]), 64'd0);
            chk("rst_ack_ignored_fix", 64'(fix_v[0]), 64'd0);
        end
        ack_force = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/verlet_frame_sequencer.md
Name: verlet_frame_sequencer

Overview:
- Master side of the node interface: generates `verlet_state` and `fix_constraint_state`, reads every node's `x_pos`/`y_pos`, and writes back constraint-corrected positions.
- Each frame: one Verlet integration pulse to all nodes, then CONSTRAINT_ITERS relaxation passes over adjacent node pairs (i, i+1).
- Pair correction is offloaded to an external constraint unit through a req/ack handshake.
- Sits between the frame timer and the node array.

Parameters:
- NUM_NODES, 8, number of chained nodes (≥2).
- CONSTRAINT_ITERS, 4, relaxation passes per frame (≥1).
- PIN_FIRST, 1, when 1 node 0 is anchored: never written back, and `c_pin_a` is asserted for pair 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  frame request, sampled only in IDLE
- x_pos_all  in  32*NUM_NODES  node x positions, node k at [32k+31:32k], Q20.12
- y_pos_all  in  32*NUM_NODES  node y positions, same packing
- verlet_state  out  1  broadcast one-cycle integration strobe
- fix_constraint_state  out  NUM_NODES  one-hot write enable, bit k writes node k
- x_fix_constraint  out  32  shared corrected-x bus
- y_fix_constraint  out  32  shared corrected-y bus
- c_req  out  1  constraint request, held until ack
- c_ax, c_ay, c_bx, c_by  out  32 each  pair operands, stable while c_req=1
- c_pin_a  out  1  node A is the anchor; the unit must not move it
- c_ack  in  1  constraint result valid; may arrive in the same cycle as c_req
- c_ax_out, c_ay_out, c_bx_out, c_by_out  in  32 each  corrected pair, valid with c_ack
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- overrun  out  1  one-cycle pulse when start=1 while busy

Behaviour:
- Reset (reset=0 at posedge):
  - state to IDLE; all outputs 0, including buses and c_* operands.
  - pair index i=0, iteration counter it=0.
  - Reset mid-frame aborts immediately; no partial write continues.
- IDLE: start=1 → VERLET. Otherwise remain.
- VERLET: verlet_state=1 for exactly this cycle → SETTLE.
- SETTLE: one idle cycle so node registers update → LOAD.
- LOAD:
  - register A = node i and B = node i+1 from x_pos_all/y_pos_all into c_ax/c_ay/c_bx/c_by.
  - c_pin_a = PIN_FIRST && i==0 → REQ.
- REQ:
  - c_req=1; operands held.
  - On c_req&&c_ack: latch the four results, drop c_req next cycle → WRITE_A. Otherwise stay; no timeout.
- WRITE_A:
  - x/y_fix_constraint = latched A.
  - fix_constraint_state bit i=1, except when PIN_FIRST && i==0, where all bits stay 0 but the cycle is still spent → WRITE_B.
- WRITE_B:
  - bus = latched B; bit i+1=1.
  - Then:
    - if i<NUM_NODES-2: i++ → LOAD.
    - else i=0: if it<CONSTRAINT_ITERS-1 then it++ → LOAD; else it=0 → DONE.
- DONE: frame_done=1 for one cycle → IDLE.
- At most one bit of fix_constraint_state is high in any cycle. It is 0 outside the WRITE states, and verlet_state is never high in the same cycle.
- Arithmetic: none on positions (pure transport); counters are $clog2-sized.
- Latency with zero-wait ack:
  - start accepted at cycle t; verlet_state high at t+1.
  - first LOAD at t+3; each pair takes 4 cycles.
  - frame_done at t+3+4·(NUM_NODES−1)·CONSTRAINT_ITERS. Defaults: t+115.
  - Each extra ack wait cycle adds 1.
- start while busy: ignored, overrun pulses that cycle. start in the DONE cycle is also overrun. start in IDLE in the cycle after DONE is accepted.
- c_ack outside REQ is ignored.
- Because pairs are processed in order, LOAD for pair i reads node i as already written by pair i−1 in the same pass.

Decomposition:
- Shared package holds:
  - state enum: IDLE, VERLET, SETTLE, LOAD, REQ, WRITE_A, WRITE_B, DONE.
  - Q20.12 format constants: FRAC_BITS=12, WORD=32.
  - pos word slice helper.
- No sub-module needed. The pair-select mux is inline.

Test Plan:
- NUM_NODES=3, ITERS=1, PIN_FIRST=1, ack tied to c_req, results = operands+0x1000; node0 pos (0x0C8000,0x00A000), node1 (0x0C8000,0x014000) → pair0:
  - WRITE_A shows no fix bit.
  - WRITE_B drives fix=3'b010 with (0x0C9000,0x015000).
  - frame_done at t+11.
- Defaults, zero-wait ack → verlet_state exactly 1 pulse at t+1; frame_done at t+115; 56 fix writes minus 4 pinned = 52 one-hot strobes.
- Ack delayed 3 cycles on every request → c_req held with stable operands; frame_done at t+115+84.
- start pulsed at t+10 and in the DONE cycle → overrun=1 both cycles; no second frame starts; next start in IDLE accepted.
- reset=0 while in REQ with c_req=1 → next cycle: all outputs 0, busy=0; a later c_ack is ignored.
- PIN_FIRST=0 → c_pin_a never high; pair 0 WRITE_A drives fix bit 0.
